// File: rtl/spi_flash_read_arbiter.sv
// spi_flash_read_arbiter
//   Shares one SPI flash between an instruction-fetch port and a data-load
//   port. Each granted request runs a full READ (0x03) transaction: 8-bit
//   command, 24-bit address, 32 data bits. The four received bytes come back
//   as one little-endian word.
//
// Parameters
//   CLK_DIV  clk_i cycles per SCK half-period (1..255)
//   CS_GAP   minimum clk_i cycles cs stays high between transactions (1..255)
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   instr_req_i/instr_addr_i      instruction read request and byte address
//   instr_gnt_o                   combinational grant, instruction port
//   instr_rvalid_o                one-cycle pulse: rdata_o is for instr port
//   data_req_i/data_addr_i        data read request and byte address
//   data_gnt_o/data_rvalid_o      grant / read-valid for the data port
//   rdata_o                       shared read word, held until next rvalid
//   busy_o                        transaction or CS gap in progress
//   sck, sdo, sdi, cs             SPI mode 0 flash pins, cs active-low
module spi_flash_read_arbiter #(
    parameter int CLK_DIV = 1,
    parameter int CS_GAP  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [23:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic        data_req_i,
    input  logic [23:0] data_addr_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        sck,
    output logic        sdo,
    input  logic        sdi,
    output logic        cs
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [7:0]  gap_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] tx;
    logic [31:0] rx;
    logic        owner_data;
    logic        last_data;   // 1: data port was granted last (or fresh reset)
    logic        idle;
    logic [31:0] cmd_word;
    logic [31:0] rx_next;

    assign idle = (state == IDLE);

    // Round-robin between two ports: a lone requester always wins, on a tie
    // the port not granted last wins. last_data resets to 1 so the
    // instruction port wins the first tie.
    assign instr_gnt_o = idle && instr_req_i && (!data_req_i || last_data);
    assign data_gnt_o  = idle && data_req_i && (!instr_req_i || !last_data);
    assign busy_o      = !idle;

    assign cmd_word = {8'h03, (data_gnt_o ? data_addr_i : instr_addr_i)};
    assign rx_next  = {rx[30:0], sdi};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cs             <= 1'b1;
            sck            <= 1'b0;
            sdo            <= 1'b0;
            div_cnt        <= '0;
            gap_cnt        <= '0;
            bit_cnt        <= '0;
            tx             <= '0;
            rx             <= '0;
            rdata_o        <= '0;
            instr_rvalid_o <= 1'b0;
            data_rvalid_o  <= 1'b0;
            owner_data     <= 1'b0;
            last_data      <= 1'b1;
        end else begin
            instr_rvalid_o <= 1'b0;
            data_rvalid_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_gnt_o || data_gnt_o) begin
                        state      <= SHIFT;
                        cs         <= 1'b0;
                        sck        <= 1'b0;
                        // Command MSB goes out with cs; tx holds the rest,
                        // and zeros shift in behind so the data phase drives 0.
                        sdo        <= cmd_word[31];
                        tx         <= {cmd_word[30:0], 1'b0};
                        owner_data <= data_gnt_o;
                        last_data  <= data_gnt_o;
                        bit_cnt    <= 6'd63;
                        div_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                        end else begin
                            // Last cycle of the high phase: sample, then fall.
                            rx  <= rx_next;
                            sck <= 1'b0;
                            if (bit_cnt == 6'd0) begin
                                cs             <= 1'b1;
                                rdata_o        <= {rx_next[7:0], rx_next[15:8],
                                                   rx_next[23:16], rx_next[31:24]};
                                instr_rvalid_o <= !owner_data;
                                data_rvalid_o  <= owner_data;
                                gap_cnt        <= GAP_LAST;
                                state          <= GAP;
                            end else begin
                                bit_cnt <= bit_cnt - 6'd1;
                                sdo     <= tx[31];
                                tx      <= {tx[30:0], 1'b0};
                            end
                        end
                    end
                end
                GAP: begin
                    // The cs-rise cycle already counted as the first gap cycle.
                    if (gap_cnt == 8'd0) state <= IDLE;
                    else                 gap_cnt <= gap_cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
